// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave core.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Returns 1 when the sample edge is the rising SCLK edge.
  // The sample edge is leading for CPHA=0 and trailing for CPHA=1.
  // For CPOL=0 the leading edge rises; for CPOL=1 it falls.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

  // Width of a counter that must hold 0..dw inclusive.
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/spi_slave_core_sync_edge.sv
// Multi-flop synchronizer followed by a change detector.
// lvl_o is the synchronized level. chg_o strobes for one cycle when that level
// toggles. Rise is lvl_o & chg_o, and fall is ~lvl_o & chg_o.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic lvl_o,
  output logic chg_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw pin into the chain; remember last synchronized level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  // Chain and edge flop reset to the idle level so reset makes no edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl_o = sync_q[STAGES-1];
  assign chg_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core. It oversamples SCLK, CS and MOSI using clk_i and supports all
// CPOL/CPHA modes. It can send several words back to back within one CS frame.
// Define SPI_SLAVE_ERR_CNT_EN to add saturating underrun and overrun counters.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter int                CPOL          = 0,
  parameter int                CPHA          = 0,
  parameter int                MSB_FIRST     = 1,
  parameter int                SYNC_STAGES   = 2,
  parameter logic [DATA_W-1:0] UNDERRUN_WORD = '1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              underrun_o,
  output logic              overrun_o
`ifdef SPI_SLAVE_ERR_CNT_EN
  ,
  output logic [7:0]        err_underrun_cnt_o,
  output logic [7:0]        err_overrun_cnt_o
`endif
);

  localparam int   CNT_W       = cnt_w(DATA_W);
  localparam logic SAMPLE_RISE = sample_on_rise(CPOL != 0, CPHA != 0);
  localparam logic SCLK_IDLE   = (CPOL != 0);

  logic sclk_lvl, sclk_chg, cs_lvl, cs_chg;
  logic sample_evt, shift_evt, cs_fall, cs_rise;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_clk_i), .lvl_o(sclk_lvl), .chg_o(sclk_chg)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_cs_i), .lvl_o(cs_lvl), .chg_o(cs_chg)
  );

  assign sample_evt = sclk_chg & (sclk_lvl == SAMPLE_RISE);
  assign shift_evt  = sclk_chg & (sclk_lvl != SAMPLE_RISE);
  assign cs_fall    = cs_chg & ~cs_lvl;
  assign cs_rise    = cs_chg &  cs_lvl;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      tx_shreg_q, tx_shreg_d;
  logic [DATA_W-1:0]      rx_shreg_q, rx_shreg_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   miso_q, miso_d;
  logic                   underrun_q, underrun_d;
  logic                   overrun_q, overrun_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  // After reset, the CS chain holds the idle value until the real pin level
  // reaches it. A CS that is already low at reset would therefore look like a
  // fresh falling edge. Frames are accepted only after the chain is flushed and
  // CS has been seen high.
  logic [SYNC_STAGES:0]   flush_q, flush_d;
  logic                   armed_q, armed_d;
  logic                   load;
  logic                   mosi_lvl;

  assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];

  // Next-state, shift-register and handshake logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shreg_d  = tx_shreg_q;
    rx_shreg_d  = rx_shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready_i;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;
    load        = 1'b0;
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (flush_q[SYNC_STAGES] & cs_lvl);

    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Abort: the partial word and any loaded tx word are dropped
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sample_evt) begin
          if (MSB_FIRST != 0) rx_shreg_d = {rx_shreg_q[DATA_W-2:0], mosi_lvl};
          else                rx_shreg_d = {mosi_lvl, rx_shreg_q[DATA_W-1:1]};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d  = rx_shreg_d;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ready_i;
            load       = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_evt && bit_cnt_q != '0) begin
          // bit_cnt==0 means a fresh word whose first bit must stay presented
          if (MSB_FIRST != 0) tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
          else                tx_shreg_d = {1'b0, tx_shreg_q[DATA_W-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      bit_cnt_d = '0;
      if (tx_valid_i) begin
        tx_shreg_d = tx_data_i;
      end else begin
        tx_shreg_d = UNDERRUN_WORD;
        underrun_d = 1'b1;
      end
    end

    if (state_d == ACTIVE) miso_d = (MSB_FIRST != 0) ? tx_shreg_d[DATA_W-1] : tx_shreg_d[0];
    else                   miso_d = 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shreg_q  <= '0;
      rx_shreg_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shreg_q  <= tx_shreg_d;
      rx_shreg_q  <= rx_shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      mosi_sync_q <= mosi_sync_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign spi_miso_o = miso_q;
  assign tx_ready_o = load & ~rst_i;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q == ACTIVE);
  assign underrun_o = underrun_q;
  assign overrun_o  = overrun_q;

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] err_un_q, err_un_d, err_ov_q, err_ov_d;

  // Saturating error counters driven by the registered pulses
  always_comb begin
    err_un_d = err_un_q;
    err_ov_d = err_ov_q;
    if (underrun_q && err_un_q != 8'hFF) err_un_d = err_un_q + 8'd1;
    if (overrun_q  && err_ov_q != 8'hFF) err_ov_d = err_ov_q + 8'd1;
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_un_q <= '0;
      err_ov_q <= '0;
    end else begin
      err_un_q <= err_un_d;
      err_ov_q <= err_ov_d;
    end
  end

  assign err_underrun_cnt_o = err_un_q;
  assign err_overrun_cnt_o  = err_ov_q;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: one instance per SPI mode, driven one at a time.
// A master model checks MISO/RX data against expected frames.
module tb_spi_slave_core;
  localparam int W = 8;
  localparam int H = 80;  // SCLK half period, 8 clk_i cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sclk [4];
  logic         cs   [4];
  logic         mosi [4];
  logic         miso [4];
  logic [W-1:0] tx_data;
  logic         tx_valid, rx_ready;
  logic         tx_ready [4];
  logic [W-1:0] rx_data  [4];
  logic         rx_valid [4];
  logic         busy     [4];
  logic         und      [4];
  logic         ovr      [4];
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0]   eu [4];
  logic [7:0]   eo [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_core #(.DATA_W(W), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .spi_clk_i(sclk[g]), .spi_cs_i(cs[g]), .spi_mosi_i(mosi[g]), .spi_miso_o(miso[g]),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready[g]),
      .rx_data_o(rx_data[g]), .rx_valid_o(rx_valid[g]), .rx_ready_i(rx_ready),
      .busy_o(busy[g]), .underrun_o(und[g]), .overrun_o(ovr[g])
`ifdef SPI_SLAVE_ERR_CNT_EN
      , .err_underrun_cnt_o(eu[g]), .err_overrun_cnt_o(eo[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event monitor: accepted rx words, error pulses, and tx load strobes
  int           un_cnt = 0, ov_cnt = 0, ld_cnt = 0;
  logic [W-1:0] rxq[$];
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 4; g++) begin
        if (rx_valid[g] && rx_ready) rxq.push_back(rx_data[g]);
        if (und[g]) un_cnt++;
        if (ovr[g]) ov_cnt++;
        if (tx_ready[g]) ld_cnt++;
      end
    end
  end

  // Master: shifts nb bits MSB first and returns what it sampled on MISO
  task automatic spi_word(input int m, input logic [W-1:0] mw, input int nb,
                          output logic [W-1:0] sw);
    logic cpol, cpha;
    cpol = 1'(m / 2);
    cpha = 1'(m % 2);
    sw = '0;
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi[m] = mw[W-1-i];
        #H;
        sw[W-1-i] = miso[m];
        sclk[m] = ~cpol;
        #H;
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = mw[W-1-i];
        #H;
        sw[W-1-i] = miso[m];
        sclk[m] = cpol;
        #H;
      end
    end
  endtask

  // Frame description consumed by run_frame
  logic [W-1:0] f_mw [4];
  logic [W-1:0] f_tw [4];
  logic         f_tv [4];

  // Expected per frame: each word's MISO is its tx word (or all ones when not
  // valid); rx returns the master words in order; one underrun per invalid
  // word; loads = one at CS fall plus one per completed word; no overruns.
  task automatic run_frame(input int m, input int n, input string tag);
    logic [W-1:0] sw, exp_w;
    int u0, o0, l0, exp_un;
    u0 = un_cnt; o0 = ov_cnt; l0 = ld_cnt; exp_un = 0;
    rxq.delete();
    tx_data = f_tw[0]; tx_valid = f_tv[0];
    #20; cs[m] = 1'b0; #100;
    for (int k = 0; k < n; k++) begin
      if (k + 1 < n) begin
        tx_data = f_tw[k+1]; tx_valid = f_tv[k+1];
      end else begin
        tx_data = W'($urandom); tx_valid = 1'b1;
      end
      spi_word(m, f_mw[k], W, sw);
      exp_w = f_tv[k] ? f_tw[k] : '1;
      if (!f_tv[k]) exp_un++;
      chk({tag, "_miso"}, 32'(sw), 32'(exp_w));
    end
    #H; cs[m] = 1'b1; #200;
    chk({tag, "_rxcnt"}, 32'(rxq.size()), 32'(n));
    for (int k = 0; k < n && rxq.size() > 0; k++)
      chk({tag, "_rx"}, 32'(rxq.pop_front()), 32'(f_mw[k]));
    chk({tag, "_underrun"}, 32'(un_cnt - u0), 32'(exp_un));
    chk({tag, "_overrun"}, 32'(ov_cnt - o0), 32'd0);
    chk({tag, "_loads"}, 32'(ld_cnt - l0), 32'(n + 1));
  endtask

  task automatic chk_zero(input int m, input string tag);
    chk({tag, "_miso"}, 32'(miso[m]), 32'd0);
    chk({tag, "_rxd"}, 32'(rx_data[m]), 32'd0);
    chk({tag, "_rxv"}, 32'(rx_valid[m]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[m]), 32'd0);
    chk({tag, "_txrdy"}, 32'(tx_ready[m]), 32'd0);
    chk({tag, "_und"}, 32'(und[m]), 32'd0);
    chk({tag, "_ovr"}, 32'(ovr[m]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] sw;
    int m, n, o0;
    for (int g = 0; g < 4; g++) begin
      sclk[g] = 1'(g / 2); cs[g] = 1'b1; mosi[g] = 1'b0;
    end
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "rst0");
    chk_zero(3, "rst3");
    @(negedge clk); rst = 1'b0;
    #200;

    // Mode 0, A5 out / 3C in
    f_mw[0] = 8'h3C; f_tw[0] = 8'hA5; f_tv[0] = 1'b1;
    run_frame(0, 1, "t1");

    // Modes 1..3, 81 out / 7E in
    for (int md = 1; md < 4; md++) begin
      f_mw[0] = 8'h7E; f_tw[0] = 8'h81; f_tv[0] = 1'b1;
      run_frame(md, 1, $sformatf("t2m%0d", md));
    end

    // Three words with a gap in tx data on word 2
    for (int k = 0; k < 3; k++) begin
      f_mw[k] = W'($urandom); f_tw[k] = W'($urandom); f_tv[k] = (k != 1);
    end
    run_frame(0, 3, "t3");

    // Random frames in random modes
    for (int it = 0; it < 10; it++) begin
      m = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) begin
        f_mw[k] = W'($urandom); f_tw[k] = W'($urandom);
        f_tv[k] = ($urandom_range(0, 3) != 0);
      end
      run_frame(m, n, $sformatf("rnd%0d", it));
    end

    // Consumer stalled across two words
    o0 = ov_cnt;
    rx_ready = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A;
    #20; cs[1] = 1'b0; #100;
    spi_word(1, 8'h11, W, sw);
    spi_word(1, 8'h22, W, sw);
    #H; cs[1] = 1'b1; #200;
    chk("t4_overrun", 32'(ov_cnt - o0), 32'd1);
    chk("t4_rxd", 32'(rx_data[1]), 32'h22);
    chk("t4_rxv", 32'(rx_valid[1]), 32'd1);
    rx_ready = 1'b1;
    #20;
    chk("t4_rxv_clr", 32'(rx_valid[1]), 32'd0);

    // Abort after 5 bits, then a clean frame
    rxq.delete();
    tx_valid = 1'b1;
    #20; cs[2] = 1'b0; #100;
    spi_word(2, 8'hC3, 5, sw);
    #H; cs[2] = 1'b1; #200;
    chk("t5_partial_rx", 32'(rxq.size()), 32'd0);
    f_mw[0] = 8'h55; f_tw[0] = 8'h69; f_tv[0] = 1'b1;
    run_frame(2, 1, "t5");

    // Reset mid-word; CS held low must not restart a frame
    rxq.delete();
    #20; cs[0] = 1'b0; #100;
    spi_word(0, 8'hF0, 3, sw);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_zero(0, "t6");
    @(negedge clk); rst = 1'b0;
    #100;
    spi_word(0, 8'hE7, W, sw);
    #200;
    chk("t6_busy", 32'(busy[0]), 32'd0);
    chk("t6_no_rx", 32'(rxq.size()), 32'd0);
    cs[0] = 1'b1; #200;
    f_mw[0] = 8'h96; f_tw[0] = 8'h3E; f_tv[0] = 1'b1;
    run_frame(0, 1, "t6");

`ifdef SPI_SLAVE_ERR_CNT_EN
    tx_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cs[0] = 1'b0; #60;
      cs[0] = 1'b1; #60;
    end
    #100;
    chk("err_un_sat", 32'(eu[0]), 32'd255);
    chk("err_ov", 32'(eo[0]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
